// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared FSM state type, word size and default WS2812 timing constants
package ws2812_pkg;

  localparam int WORD_BITS        = 24;
  localparam int DEF_BIT_THRESH   = 30;
  localparam int DEF_MAX_HIGH     = 60;
  localparam int DEF_LATCH_CYCLES = 2500;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  // Counters must hold one step past the larger limit so "exceeds" is observable.
  function automatic int cnt_width(input int max_a, input int max_b);
    int m;
    m = (max_a > max_b) ? max_a : max_b;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// rtl/ws2812_pulse_meter.sv - din synchronizer, edge detect and saturating high/low run-length counters
module ws2812_pulse_meter
  import ws2812_pkg::*;
#(
  parameter int CNT_W = cnt_width(DEF_LATCH_CYCLES, DEF_MAX_HIGH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_din,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_low_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_low_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (o_rise) begin
        r_high_cnt <= CNT_ONE;
      end else if (r_sync2 && (r_high_cnt != CNT_MAX)) begin
        r_high_cnt <= r_high_cnt + CNT_ONE;
      end

      // Low count restarts on any high level so it measures only uninterrupted gaps.
      if (r_sync2) begin
        r_low_cnt <= '0;
      end else if (o_fall) begin
        r_low_cnt <= CNT_ONE;
      end else if (r_low_cnt != CNT_MAX) begin
        r_low_cnt <= r_low_cnt + CNT_ONE;
      end
    end
  end

  assign o_rise     = r_sync2 & ~r_prev;
  assign o_fall     = ~r_sync2 & r_prev;
  assign o_high_cnt = r_high_cnt;
  assign o_low_cnt  = r_low_cnt;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 receiver: pulse-width decode FSM and valid/ready 24-bit output register
// Defining WS2812_RX_STATS_EN adds the o_pixel_count per-frame word counter.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int BIT_THRESH   = DEF_BIT_THRESH,
  parameter int MAX_HIGH     = DEF_MAX_HIGH,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_din,
  output logic [WORD_BITS-1:0] o_rgb_data,
  output logic                 o_rgb_valid,
  input  logic                 i_rgb_ready,
  output logic                 o_frame_end,
  output logic                 o_err
`ifdef WS2812_RX_STATS_EN
  ,
  output logic [15:0]          o_pixel_count
`endif
);

  localparam int CNT_W = cnt_width(LATCH_CYCLES, MAX_HIGH);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] LATCH_C    = CNT_W'(LATCH_CYCLES);
  localparam logic [4:0]       LAST_BIT   = 5'(WORD_BITS - 1);

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_high_cnt;
  logic [CNT_W-1:0] w_low_cnt;

  ws2812_pulse_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_din      (i_din),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_high_cnt (w_high_cnt),
    .o_low_cnt  (w_low_cnt)
  );

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_BITS-2:0] r_shift;
  logic [4:0]           r_bit_cnt;
  logic [WORD_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_end;
  logic                 r_err;

  logic                 w_shift_en;
  logic                 w_clear_bits;
  logic                 w_frame_end_nxt;
  logic                 w_err_fsm;
  logic                 w_bit;
  logic [WORD_BITS-1:0] w_word;
  logic                 w_word_done;
  logic                 w_handshake;
  logic                 w_overflow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_en      = 1'b0;
    w_clear_bits    = 1'b0;
    w_frame_end_nxt = 1'b0;
    w_err_fsm       = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_low_cnt >= LATCH_C) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_high_cnt > MAX_HIGH_C) begin
          w_err_fsm    = 1'b1;
          w_clear_bits = 1'b1;
          w_state_nxt  = ST_SYNC;
        end else if (w_fall) begin
          w_shift_en  = 1'b1;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
        end else if (w_low_cnt >= LATCH_C) begin
          w_frame_end_nxt = 1'b1;
          w_clear_bits    = 1'b1;
          w_err_fsm       = (r_bit_cnt != '0);
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  assign w_bit       = (w_high_cnt >= THRESH_C);
  assign w_word      = {r_shift, w_bit};
  assign w_word_done = w_shift_en && (r_bit_cnt == LAST_BIT);
  assign w_handshake = r_valid && i_rgb_ready;
  // A completed word may only replace the held one if that one leaves this same cycle.
  assign w_overflow  = w_word_done && r_valid && !i_rgb_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_end <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_frame_end <= w_frame_end_nxt;
      r_err       <= w_err_fsm || w_overflow;

      if (w_clear_bits) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= w_word[WORD_BITS-2:0];
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? 5'd0 : r_bit_cnt + 5'd1;
      end

      if (w_word_done && (!r_valid || i_rgb_ready)) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rgb_data  = r_data;
  assign o_rgb_valid = r_valid;
  assign o_frame_end = r_frame_end;
  assign o_err       = r_err;

`ifdef WS2812_RX_STATS_EN
  logic [15:0] r_pixel_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pixel_cnt <= '0;
    end else if (r_frame_end) begin
      r_pixel_cnt <= '0;
    end else if (w_word_done && (r_pixel_cnt != 16'hFFFF)) begin
      r_pixel_cnt <= r_pixel_cnt + 16'd1;
    end
  end

  assign o_pixel_count = r_pixel_cnt;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard testbench for ws2812_rx
`timescale 1ns/1ps
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int LATCH = DEF_LATCH_CYCLES;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_din = 1'b0;
  logic        i_rgb_ready = 1'b0;
  logic [23:0] o_rgb_data;
  logic        o_rgb_valid;
  logic        o_frame_end;
  logic        o_err;
`ifdef WS2812_RX_STATS_EN
  logic [15:0] o_pixel_count;
`endif

  ws2812_rx dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_din       (i_din),
    .o_rgb_data  (o_rgb_data),
    .o_rgb_valid (o_rgb_valid),
    .i_rgb_ready (i_rgb_ready),
    .o_frame_end (o_frame_end),
    .o_err       (o_err)
`ifdef WS2812_RX_STATS_EN
    ,
    .o_pixel_count (o_pixel_count)
`endif
  );

  always #10 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];
  logic [23:0] sb_exp;
  int err_cnt, fe_cnt, both_cnt, vld_cyc, hs_cnt;
  int err_cyc, fe_cyc, first_vld_cyc, last_fall_cyc, rise_cyc;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_err) begin err_cnt++; err_cyc = cyc; end
      if (o_frame_end) begin fe_cnt++; fe_cyc = cyc; end
      if (o_err && o_frame_end) both_cnt++;
      if (o_rgb_valid) begin
        vld_cyc++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (o_rgb_valid && i_rgb_ready) begin
        hs_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_word: got %06h, required no word", o_rgb_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (o_rgb_data !== sb_exp) begin
            n_bad++;
            $display("FAIL sb_word: got %06h, required %06h", o_rgb_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic clear_mon();
    err_cnt = 0; fe_cnt = 0; both_cnt = 0; vld_cyc = 0; hs_cnt = 0;
    err_cyc = -1; fe_cyc = -1; first_vld_cyc = -1;
  endtask

  task automatic do_reset(input logic rdy);
    i_reset = 1'b1;
    i_din = 1'b0;
    i_rgb_ready = rdy;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
    clear_mon();
  endtask

  task automatic hold(input logic level, input int n);
    i_din = level;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    hold(1'b1, hi);
    last_fall_cyc = cyc;
    hold(1'b0, lo);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (w[i]) send_pulse(40, 20);
      else send_pulse(20, 40);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_din = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    n_cmp++; if (o_rgb_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %06h, required 000000", o_rgb_data); end
    n_cmp++; if (o_rgb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", o_rgb_valid); end
    n_cmp++; if (o_frame_end !== 1'b0) begin n_bad++; $display("FAIL reset_frame_end: got %b, required 0", o_frame_end); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b, required 0", o_err); end
`ifdef WS2812_RX_STATS_EN
    n_cmp++; if (o_pixel_count !== 16'h0) begin n_bad++; $display("FAIL reset_pixel_count: got %0d, required 0", o_pixel_count); end
`endif
    i_reset = 1'b0;
    clear_mon();
    hold(1'b0, 20);
    n_cmp++; if (err_cnt + fe_cnt + vld_cyc !== 0) begin n_bad++; $display("FAIL reset_release_pulses: got %0d, required 0", err_cnt + fe_cnt + vld_cyc); end
  endtask

  task automatic test_single_word();
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    exp_q.push_back(24'h00FF00);
    send_bits(24'h00FF00, 24);
    hold(1'b0, LATCH + 20);
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL single_handshakes: got %0d, required 1", hs_cnt); end
    n_cmp++; if (vld_cyc !== 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d, required 1", vld_cyc); end
    n_cmp++; if (first_vld_cyc !== last_fall_cyc + 3) begin n_bad++; $display("FAIL single_valid_latency: got %0d, required %0d", first_vld_cyc, last_fall_cyc + 3); end
    n_cmp++; if (fe_cnt !== 1) begin n_bad++; $display("FAIL single_frame_end_count: got %0d, required 1", fe_cnt); end
    n_cmp++; if (fe_cyc !== last_fall_cyc + LATCH + 3) begin n_bad++; $display("FAIL single_frame_end_cycle: got %0d, required %0d", fe_cyc, last_fall_cyc + LATCH + 3); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL single_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL single_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    hold(1'b0, LATCH + 10);
    exp_q.push_back(24'h123456);
    send_bits(24'h123456, 24);
    send_bits(24'hABCDEF, 24);
    hold(1'b0, 50);
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL ovf_err_count: got %0d, required 1", err_cnt); end
    n_cmp++; if (err_cyc !== last_fall_cyc + 3) begin n_bad++; $display("FAIL ovf_err_cycle: got %0d, required %0d", err_cyc, last_fall_cyc + 3); end
    n_cmp++; if (o_rgb_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid_held: got %b, required 1", o_rgb_valid); end
    n_cmp++; if (o_rgb_data !== 24'h123456) begin n_bad++; $display("FAIL ovf_data_held: got %06h, required 123456", o_rgb_data); end
    i_rgb_ready = 1'b1;
    hold(1'b0, 5);
    i_rgb_ready = 1'b0;
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL ovf_handshakes: got %0d, required 1", hs_cnt); end
    n_cmp++; if (o_rgb_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_valid_cleared: got %b, required 0", o_rgb_valid); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL ovf_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] wa, wb;
    wa = 24'h5A3C96;
    wb = 24'hC3A5F1;
    do_reset(1'b0);
    hold(1'b0, LATCH + 10);
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    send_bits(wa, 24);
    send_bits(wb >> 1, 23);
    hold(1'b1, 40);
    last_fall_cyc = cyc;
    hold(1'b0, 2);
    i_rgb_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rgb_ready = 1'b0;
    hold(1'b0, 20);
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL b2b_first_handshake: got %0d, required 1", hs_cnt); end
    n_cmp++; if (o_rgb_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_kept: got %b, required 1", o_rgb_valid); end
    n_cmp++; if (o_rgb_data !== wb) begin n_bad++; $display("FAIL b2b_data: got %06h, required %06h", o_rgb_data, wb); end
    i_rgb_ready = 1'b1;
    hold(1'b0, 3);
    n_cmp++; if (hs_cnt !== 2) begin n_bad++; $display("FAIL b2b_handshakes: got %0d, required 2", hs_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_thresholds();
    int widths[4];
    widths = '{29, 30, 60, 45};
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    exp_q.push_back(24'h777777);
    for (int i = 0; i < 24; i++) send_pulse(widths[i % 4], 25);
    hold(1'b0, 10);
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL thresh_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL thresh_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_malformed();
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    send_bits(24'h000015, 5);
    rise_cyc = cyc;
    hold(1'b1, 70);
    hold(1'b0, LATCH + 10);
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL malformed_err: got %0d, required 1", err_cnt); end
    n_cmp++; if (err_cyc !== rise_cyc + DEF_MAX_HIGH + 4) begin n_bad++; $display("FAIL malformed_err_cycle: got %0d, required %0d", err_cyc, rise_cyc + DEF_MAX_HIGH + 4); end
    n_cmp++; if (vld_cyc !== 0) begin n_bad++; $display("FAIL malformed_no_valid: got %0d, required 0", vld_cyc); end
    exp_q.push_back(24'hA5C3E1);
    send_bits(24'hA5C3E1, 24);
    hold(1'b0, 30);
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL malformed_recover: got %0d, required 1", hs_cnt); end
    n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL malformed_frame_end: got %0d, required 0", fe_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL malformed_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_partial();
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    send_bits(24'h0002B5, 10);
    hold(1'b0, LATCH + 20);
    n_cmp++; if (fe_cnt !== 1) begin n_bad++; $display("FAIL partial_frame_end: got %0d, required 1", fe_cnt); end
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL partial_err: got %0d, required 1", err_cnt); end
    n_cmp++; if (both_cnt !== 1) begin n_bad++; $display("FAIL partial_same_cycle: got %0d, required 1", both_cnt); end
    n_cmp++; if (fe_cyc !== last_fall_cyc + LATCH + 3) begin n_bad++; $display("FAIL partial_frame_end_cycle: got %0d, required %0d", fe_cyc, last_fall_cyc + LATCH + 3); end
    n_cmp++; if (vld_cyc !== 0) begin n_bad++; $display("FAIL partial_no_valid: got %0d, required 0", vld_cyc); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    send_bits(24'h000FFF, 12);
    i_reset = 1'b1;
    hold(1'b1, 4);
    n_cmp++; if ({o_rgb_data, o_rgb_valid, o_frame_end, o_err} !== 27'h0) begin n_bad++; $display("FAIL midreset_outputs: got %07h, required 0", {o_rgb_data, o_rgb_valid, o_frame_end, o_err}); end
    i_reset = 1'b0;
    clear_mon();
    send_bits(24'h111111, 24);
    n_cmp++; if (vld_cyc + err_cnt + fe_cnt !== 0) begin n_bad++; $display("FAIL midreset_resync: got %0d events, required 0", vld_cyc + err_cnt + fe_cnt); end
    hold(1'b0, LATCH + 10);
    exp_q.push_back(24'h0F0F0F);
    send_bits(24'h0F0F0F, 24);
    hold(1'b0, 30);
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL midreset_word: got %0d, required 1", hs_cnt); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL midreset_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL midreset_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    logic [23:0] w;
    logic found;
    do_reset(1'b1);
    hold(1'b0, LATCH + 10);
    for (int i = 0; i < 3; i++) begin
      w = 24'($urandom);
      exp_q.push_back(w);
      send_bits(w, 24);
    end
    found = 1'b0;
    for (int k = 0; k < LATCH + 100 && !found; k++) begin
      @(negedge i_clk);
      if (o_frame_end) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL stream_frame_end_timeout: got %b, required 1", found); end
`ifdef WS2812_RX_STATS_EN
    if (found) begin
      n_cmp++; if (o_pixel_count !== 16'd3) begin n_bad++; $display("FAIL stats_count_at_frame_end: got %0d, required 3", o_pixel_count); end
      @(negedge i_clk);
      n_cmp++; if (o_pixel_count !== 16'd0) begin n_bad++; $display("FAIL stats_count_cleared: got %0d, required 0", o_pixel_count); end
    end
`endif
    hold(1'b0, 5);
    n_cmp++; if (hs_cnt !== 3) begin n_bad++; $display("FAIL stream_handshakes: got %0d, required 3", hs_cnt); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL stream_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL stream_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_word();
    test_overflow();
    test_back_to_back();
    test_thresholds();
    test_malformed();
    test_partial();
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
- REQ-001: Parameter BIT_THRESH, default 30; high-time in clk cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- REQ-002: Parameter MAX_HIGH, default 60; high-time in cycles above which a pulse is malformed.
- REQ-003: Parameter LATCH_CYCLES, default 2500; low-time in cycles that ends a frame (50 us at 50 MHz).
- REQ-004: clk  input  1  single system clock (MAX10_CLK1_50 domain), all logic on rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: din  input  1  asynchronous WS2812 serial data line.
- REQ-007: rgb_data  output  24  decoded word, GRB order, MSB first on the wire.
- REQ-008: rgb_valid  output  1  rgb_data holds an unconsumed word.
- REQ-009: rgb_ready  input  1  consumer accepts the word when rgb_valid and rgb_ready are both high on a clk edge.
- REQ-010: frame_end  output  1  one-cycle pulse when a latch gap is detected.
- REQ-011: err  output  1  one-cycle pulse on malformed pulse, partial word, or overflow.

Function
- REQ-012: din SHALL pass through a 2-FF synchronizer; all decoding SHALL use the synchronized value, adding 2 cycles of latency.
- REQ-013: The FSM SHALL have states SYNC, IDLE, HIGH, and LOW.
- REQ-014: SYNC: count low cycles, cleared whenever din is high; reaching LATCH_CYCLES -> IDLE with no frame_end pulse.
- REQ-015: IDLE: a rising edge -> HIGH with the high counter set to 1.
- REQ-016: HIGH: increment the high counter while din is high.
  - Counter exceeds MAX_HIGH -> err pulse, discard partial bits, go to SYNC.
  - Falling edge -> shift in bit = (count >= BIT_THRESH), go to LOW with the low counter set to 1.
- REQ-017: LOW: increment the low counter.
  - Rising edge -> HIGH.
  - Low counter reaches LATCH_CYCLES -> frame_end pulse and go to IDLE.
  - If the bit count is nonzero at that point, also pulse err and discard the partial bits.
- REQ-018: When the 24th bit is shifted in, the word SHALL load into rgb_data and rgb_valid SHALL assert on the next cycle.
- REQ-019: The bit counter SHALL wrap to 0 after the 24th bit, so the next bit starts a new word.
- REQ-020: If a word completes while rgb_valid=1 and rgb_ready=0, the new word SHALL be dropped, err SHALL pulse, and the held word SHALL remain unchanged.
- REQ-021: If a word completes in the same cycle as a handshake, the new word SHALL load, rgb_valid SHALL remain 1, and there is no err.
- REQ-022: rgb_valid SHALL clear the cycle after a handshake unless REQ-021 applies.
- REQ-023: rgb_data SHALL be stable while rgb_valid=1.
- REQ-024: The shift register, all counters, and the frame_end/err pulses SHALL be registered.

Reset
- REQ-025: On reset, the FSM SHALL enter SYNC with all counters at 0.
- REQ-026: On reset, rgb_data=0, rgb_valid=0, frame_end=0, err=0, and the synchronizer flops SHALL be 0.
- REQ-027: Reset asserted mid-frame SHALL discard all partial and held data; no output pulses SHALL occur during or on release of reset.

Configuration
- REQ-028: With WS2812_RX_STATS_EN defined, the block SHALL add output pixel_count[15:0].
  - Increments once per completed word, whether accepted or dropped.
  - Saturates at 16'hFFFF.
  - Clears to 0 in the cycle after frame_end and on reset.
- REQ-029: Without WS2812_RX_STATS_EN, pixel_count and its counter SHALL not exist.

Structure
- REQ-030: A shared package ws2812_pkg SHALL hold the FSM state typedef, the WORD_BITS=24 constant, and the default timing constants.
- REQ-031: Sub-module ws2812_pulse_meter SHALL contain the synchronizer, edge detection, and high/low counters; the FSM and output register SHALL reside in ws2812_rx.

Verification
- REQ-032: Reset, then 2500 low cycles, then 24 bits of 0x00FF00 (ones 40 high/20 low, zeros 20 high/40 low) with rgb_ready=1 -> rgb_data=24'h00FF00, one rgb_valid cycle, then frame_end after the 2500-cycle gap, err never asserted.
- REQ-033: Two back-to-back words 0x123456 and 0xABCDEF with rgb_ready=0 -> first word held, err pulses once at the second word's 24th bit; raising rgb_ready then yields 24'h123456 only.
- REQ-034: A 70-cycle high pulse mid-word -> err pulse, no rgb_valid; a subsequent 2500-cycle gap plus a valid word -> correct word decoded.
- REQ-035: 10 bits followed by a 2500-cycle low gap -> frame_end and err pulse in the same cycle, no rgb_valid.
- REQ-036: Reset asserted after bit 12 of a word and released -> all outputs 0; the following word decodes only after a 2500-cycle low gap.
- REQ-037: With WS2812_RX_STATS_EN, a 3-word frame -> pixel_count=3 before frame_end and 0 one cycle after it.
